vram_arbiter: RTL and testbench

Downstream consumer of the 6502 bus-interface bus-master port. It decodes each bus-master access onto a 32-bit single-port VRAM or a peripheral register bus, and shares the VRAM with the video fetch engine under fixed CPU priority. It returns read bytes with exactly one cycle of latency, which is the latency the bus-master side samples at.

---
 rtl/vram_arbiter_pkg.sv | 24 ++
 rtl/vram_arbiter.sv | 105 ++++++++++
 tb/tb_vram_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared address-map constants and grant-state encoding for the VRAM arbiter.
package vram_arbiter_pkg;

  localparam int BM_AW  = 19;
  localparam int RAM_AW = 15;
  localparam int PER_AW = 11;

  localparam logic [1:0] REG_VRAM   = 2'b00;
  localparam logic [1:0] REG_PERIPH = 2'b01;

  // Which requester owned the previous cycle, i.e. whose response is due now.
  typedef enum logic [2:0] {
    LAST_NONE,
    LAST_BM_RAM,
    LAST_BM_PER,
    LAST_BM_ZERO,
    LAST_VID
  } last_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Decodes bus-master accesses onto VRAM / peripheral bus and shares the VRAM
// port with the video fetcher; the bus master always wins the port.
module vram_arbiter
  import vram_arbiter_pkg::*;
(
  input  logic                bm_clk,
  input  logic                bm_reset,
  input  logic [BM_AW-1:0]    bm_addr,
  input  logic [7:0]          bm_wrdata,
  input  logic                bm_strobe,
  input  logic                bm_write,
  output logic [7:0]          bm_rddata,
  input  logic                vid_req,
  input  logic [RAM_AW-1:0]   vid_addr,
  output logic                vid_ack,
  output logic [31:0]         vid_rddata,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_wrdata,
  output logic [3:0]          ram_wrbytesel,
  output logic                ram_write,
  input  logic [31:0]         ram_rddata,
  output logic                periph_strobe,
  output logic                periph_write,
  output logic [PER_AW-1:0]   periph_addr,
  output logic [7:0]          periph_wrdata,
  input  logic [7:0]          periph_rddata
);

  last_e       r_last;
  logic [1:0]  r_lane;
  logic        r_vid_inflight;

  logic [1:0]  w_region;
  logic        w_bm_ram;
  logic        w_bm_per;
  logic        w_ram_wr;
  logic        w_vid_grant;
  last_e       w_last_next;

  assign w_region = bm_addr[18:17];
  assign w_bm_ram = bm_strobe && (w_region == REG_VRAM);
  assign w_bm_per = bm_strobe && (w_region == REG_PERIPH);
  assign w_ram_wr = w_bm_ram && bm_write;

  // In the ack cycle vid_req is still high for the request being answered,
  // so the inflight flag suppresses a duplicate grant.
  assign w_vid_grant = vid_req && !w_bm_ram && !r_vid_inflight;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge bm_clk or posedge bm_reset) begin
    if (bm_reset) begin
      r_last         <= LAST_NONE;
      r_lane         <= 2'b00;
      r_vid_inflight <= 1'b0;
    end else begin
      r_last         <= w_last_next;
      r_lane         <= bm_addr[1:0];
      r_vid_inflight <= w_vid_grant;
    end
  end

  // Next-state: the bus-master read wins the label; video keeps its own flag
  // because a peripheral/unmapped access and a video grant can share a cycle.
  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch forms.
    w_last_next = LAST_NONE;
    if (bm_strobe && !bm_write) begin
      case (w_region)
        REG_VRAM:   w_last_next = LAST_BM_RAM;
        REG_PERIPH: w_last_next = LAST_BM_PER;
        default:    w_last_next = LAST_BM_ZERO;
      endcase
    end else if (w_vid_grant && !bm_strobe) begin
      w_last_next = LAST_VID;
    end
  end

  // Response outputs for the cycle after the grant.
  always_comb begin
    bm_rddata = 8'h00;
    case (r_last)
      LAST_BM_RAM: bm_rddata = ram_rddata[{r_lane, 3'b000} +: 8];
      LAST_BM_PER: bm_rddata = periph_rddata;
      default:     bm_rddata = 8'h00;
    endcase
  end

  assign vid_ack    = r_vid_inflight;
  assign vid_rddata = r_vid_inflight ? ram_rddata : 32'h0;

  // VRAM port mux, resolved combinationally in the grant cycle.
  assign ram_addr      = w_bm_ram ? bm_addr[16:2] : vid_addr;
  assign ram_write     = w_ram_wr;
  assign ram_wrdata    = w_ram_wr ? {4{bm_wrdata}} : 32'h0;
  assign ram_wrbytesel = w_ram_wr ? lane_mask(bm_addr[1:0]) : 4'b0000;

  // Peripheral bus: bits 16:11 are dropped, so the region mirrors.
  assign periph_strobe = w_bm_per;
  assign periph_write  = w_bm_per && bm_write;
  assign periph_addr   = bm_addr[PER_AW-1:0];
  assign periph_wrdata = bm_wrdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized and directed bench for vram_arbiter against a transaction-level
// model of the memory map and the request/response timing.
module tb_vram_arbiter;

  logic        bm_clk = 1'b0;
  logic        bm_reset;
  logic [18:0] bm_addr;
  logic [7:0]  bm_wrdata;
  logic        bm_strobe;
  logic        bm_write;
  logic [7:0]  bm_rddata;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic        vid_ack;
  logic [31:0] vid_rddata;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;
  logic        periph_strobe;
  logic        periph_write;
  logic [10:0] periph_addr;
  logic [7:0]  periph_wrdata;
  logic [7:0]  periph_rddata;

  int n_checks = 0;
  int n_errors = 0;

  vram_arbiter dut (
    .bm_clk(bm_clk), .bm_reset(bm_reset), .bm_addr(bm_addr), .bm_wrdata(bm_wrdata),
    .bm_strobe(bm_strobe), .bm_write(bm_write), .bm_rddata(bm_rddata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rddata(vid_rddata),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel),
    .ram_write(ram_write), .ram_rddata(ram_rddata),
    .periph_strobe(periph_strobe), .periph_write(periph_write), .periph_addr(periph_addr),
    .periph_wrdata(periph_wrdata), .periph_rddata(periph_rddata)
  );

  always #5 bm_clk = ~bm_clk;

  function automatic logic [31:0] init_word(input int w);
    return 32'hDEAD_0000 | 32'(w);
  endfunction

  // Environment: synchronous single-port VRAM with byte enables.
  logic [31:0] vram [0:32767];
  always @(posedge bm_clk) begin
    if (ram_write)
      for (int b = 0; b < 4; b++)
        if (ram_wrbytesel[b]) vram[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
    ram_rddata <= vram[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressable picture of VRAM plus the responses due next cycle.
  logic [31:0] mmem [0:32767];
  logic        chk_en = 1'b0;
  logic        m_exp_ack = 1'b0;
  logic [31:0] m_exp_vword = 32'h0;
  logic        m_exp_per = 1'b0;
  logic [7:0]  m_exp_rd = 8'h00;
  logic        m_vid_done = 1'b0;
  logic [1:0]  m_rg;
  logic        m_bm_ram, m_bm_per, m_vgrant;
  logic [31:0] m_word;

  always @(negedge bm_clk) begin
    if (chk_en) begin
      if (bm_reset) begin
        check("rst_bm_rddata", 32'(bm_rddata), 32'h0);
        check("rst_vid_ack", 32'(vid_ack), 32'h0);
        check("rst_vid_rddata", vid_rddata, 32'h0);
        check("rst_ram_write", 32'(ram_write), 32'h0);
        check("rst_periph_strobe", 32'(periph_strobe), 32'h0);
        m_exp_ack = 1'b0;
        m_exp_per = 1'b0;
        m_exp_rd  = 8'h00;
      end else begin
        check("bm_rddata", 32'(bm_rddata), 32'(m_exp_per ? periph_rddata : m_exp_rd));
        check("vid_ack", 32'(vid_ack), 32'(m_exp_ack));
        check("vid_rddata", vid_rddata, m_exp_ack ? m_exp_vword : 32'h0);
        if (m_exp_ack) m_vid_done = 1'b1;

        m_rg     = bm_addr[18:17];
        m_bm_ram = bm_strobe && (m_rg == 2'd0);
        m_bm_per = bm_strobe && (m_rg == 2'd1);
        m_vgrant = vid_req && !m_bm_ram && !m_exp_ack;

        check("ram_addr", 32'(ram_addr), 32'(m_bm_ram ? bm_addr[16:2] : vid_addr));
        check("ram_write", 32'(ram_write), 32'(m_bm_ram && bm_write));
        check("ram_wrbytesel", 32'(ram_wrbytesel),
              (m_bm_ram && bm_write) ? (32'h1 << bm_addr[1:0]) : 32'h0);
        if (m_bm_ram && bm_write) check("ram_wrdata", ram_wrdata, {4{bm_wrdata}});
        check("periph_strobe", 32'(periph_strobe), 32'(m_bm_per));
        check("periph_write", 32'(periph_write), 32'(m_bm_per && bm_write));
        if (m_bm_per) begin
          check("periph_addr", 32'(periph_addr), 32'(bm_addr[10:0]));
          if (bm_write) check("periph_wrdata", 32'(periph_wrdata), 32'(bm_wrdata));
        end

        m_word      = mmem[bm_addr[16:2]];
        m_exp_ack   = m_vgrant;
        m_exp_vword = mmem[vid_addr];
        m_exp_per   = m_bm_per && !bm_write;
        m_exp_rd    = (m_bm_ram && !bm_write) ? 8'(m_word >> (8 * bm_addr[1:0])) : 8'h00;
        if (m_bm_ram && bm_write) mmem[bm_addr[16:2]][8*bm_addr[1:0] +: 8] = bm_wrdata;
      end
    end
  end

  task automatic drive(input logic rst, input logic s, input logic w, input logic [18:0] a,
                       input logic [7:0] d, input logic vr, input logic [14:0] va,
                       input logic [7:0] prd);
    @(posedge bm_clk);
    #2;
    bm_reset = rst; bm_strobe = s; bm_write = w; bm_addr = a; bm_wrdata = d;
    vid_req = vr; vid_addr = va; periph_rddata = prd;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int acks;
  logic        cur_vreq;
  logic [14:0] cur_vaddr;
  logic        r_rst, r_s, r_w;
  logic [18:0] r_a;
  int          pick;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      vram[i] = init_word(i);
      mmem[i] = init_word(i);
    end
    bm_reset = 1'b1; bm_strobe = 1'b0; bm_write = 1'b0; bm_addr = '0; bm_wrdata = '0;
    vid_req = 1'b0; vid_addr = '0; periph_rddata = '0;
    #12;
    check("init_bm_rddata", 32'(bm_rddata), 32'h0);
    check("init_vid_ack", 32'(vid_ack), 32'h0);
    check("init_vid_rddata", vid_rddata, 32'h0);
    check("init_ram_write", 32'(ram_write), 32'h0);
    check("init_periph_strobe", 32'(periph_strobe), 32'h0);
    chk_en = 1'b1;
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);

    // Byte write then read-back with one cycle latency.
    drive(0, 1, 1, 19'h00006, 8'hA5, 0, 15'h0, 8'h00);
    check("t1_wrbytesel", 32'(ram_wrbytesel), 32'h4);
    check("t1_wrdata", ram_wrdata, 32'hA5A5A5A5);
    check("t1_ram_write", 32'(ram_write), 32'h1);
    check("t1_ram_addr", 32'(ram_addr), 32'h1);
    drive(0, 1, 0, 19'h00006, 8'h00, 0, 15'h0, 8'h00);
    check("t1_rd_ram_write", 32'(ram_write), 32'h0);
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);
    check("t1_rddata", 32'(bm_rddata), 32'hA5);

    // Bus master beats a simultaneous video request.
    drive(0, 1, 0, 19'h00010, 8'h00, 1, 15'h1, 8'h00);
    check("t2_bm_first", 32'(ram_addr), 32'h4);
    drive(0, 0, 0, 19'h0, 8'h00, 1, 15'h1, 8'h00);
    check("t2_vid_grant_addr", 32'(ram_addr), 32'h1);
    check("t2_no_ack_yet", 32'(vid_ack), 32'h0);
    check("t2_bm_rddata", 32'(bm_rddata), 32'h04);
    drive(0, 0, 0, 19'h0, 8'h00, 1, 15'h1, 8'h00);
    check("t2_vid_ack", 32'(vid_ack), 32'h1);
    check("t2_vid_rddata", vid_rddata, 32'hDEA50001);
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);
    check("t2_single_ack", 32'(vid_ack), 32'h0);
    check("t2_vid_rddata_idle", vid_rddata, 32'h0);

    // Peripheral read overlapping a video grant.
    drive(0, 1, 0, 19'h20013, 8'h00, 1, 15'h3, 8'h00);
    check("t3_periph_strobe", 32'(periph_strobe), 32'h1);
    check("t3_periph_addr", 32'(periph_addr), 32'h013);
    check("t3_vid_grant", 32'(ram_addr), 32'h3);
    drive(0, 0, 0, 19'h0, 8'h00, 1, 15'h3, 8'h3C);
    check("t3_bm_rddata", 32'(bm_rddata), 32'h3C);
    check("t3_vid_ack", 32'(vid_ack), 32'h1);
    check("t3_vid_rddata", vid_rddata, 32'hDEAD0003);
    check("t3_periph_strobe_off", 32'(periph_strobe), 32'h0);
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);

    // Unmapped read and write.
    drive(0, 1, 0, 19'h40000, 8'h00, 0, 15'h0, 8'hFF);
    check("t4_rd_ram_write", 32'(ram_write), 32'h0);
    check("t4_rd_periph", 32'(periph_strobe), 32'h0);
    drive(0, 1, 1, 19'h7FFFF, 8'h77, 0, 15'h0, 8'hFF);
    check("t4_rddata_zero", 32'(bm_rddata), 32'h0);
    check("t4_wr_ram_write", 32'(ram_write), 32'h0);
    check("t4_wr_periph", 32'(periph_strobe), 32'h0);
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'hFF);
    check("t4_after_wr", 32'(bm_rddata), 32'h0);

    // Continuous video request: grant/ack alternate.
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 19'h0, 8'h00, 1, 15'h7, 8'h00);
      if (vid_ack) acks++;
    end
    check("t5_ack_count", 32'(acks), 32'd3);
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);

    // Reset lands on the ack cycle: ack is lost, held request is re-granted.
    drive(0, 0, 0, 19'h0, 8'h00, 1, 15'h5, 8'h00);
    drive(1, 0, 0, 19'h0, 8'h00, 1, 15'h5, 8'h00);
    check("t6_no_ack", 32'(vid_ack), 32'h0);
    check("t6_vid_rddata", vid_rddata, 32'h0);
    check("t6_bm_rddata", 32'(bm_rddata), 32'h0);
    drive(1, 0, 0, 19'h0, 8'h00, 1, 15'h5, 8'h00);
    drive(0, 0, 0, 19'h0, 8'h00, 1, 15'h5, 8'h00);
    check("t6_release_no_ack", 32'(vid_ack), 32'h0);
    drive(0, 0, 0, 19'h0, 8'h00, 1, 15'h5, 8'h00);
    check("t6_reack", 32'(vid_ack), 32'h1);
    check("t6_reack_data", vid_rddata, 32'hDEAD0005);
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);

    // Randomized traffic; video requests obey hold-until-ack.
    m_vid_done = 1'b0;
    cur_vreq   = 1'b0;
    cur_vaddr  = '0;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      if (m_vid_done) begin
        m_vid_done = 1'b0;
        cur_vreq   = ($urandom_range(0, 1) == 1);
        cur_vaddr  = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
      end else if (!cur_vreq && $urandom_range(0, 2) == 0) begin
        cur_vreq  = 1'b1;
        cur_vaddr = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
      end
      r_s  = !r_rst && ($urandom_range(0, 9) < 4);
      r_w  = ($urandom_range(0, 1) == 1);
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      r_a = {2'b00, 17'($urandom)};
      else if (pick < 6)  r_a = {2'b00, 17'($urandom_range(0, 63))};
      else if (pick < 8)  r_a = {2'b01, 17'($urandom)};
      else                r_a = {1'b1, 18'($urandom)};
      drive(r_rst, r_s, r_w, r_a, 8'($urandom), cur_vreq, cur_vaddr, 8'($urandom));
    end
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);
    drive(0, 0, 0, 19'h0, 8'h00, 0, 15'h0, 8'h00);
    @(negedge bm_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
